// File: rtl/da_player.sv
// rtl/da_player.sv - playback sequencer: reads a run of bytes from the receive buffer into the DAC at a fixed period.
// Buffer read path is pipelined (address reg + OCE output reg), so each issue is captured two cycles later.
module da_player #(
  parameter logic [7:0] IDLE_CODE = 8'h80,
  parameter int         PER_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [13:0]      base,
  input  logic [13:0]      len,
  input  logic [PER_W-1:0] period,
  input  logic             loop,
  output logic [13:0]      adb,
  output logic             ceb,
  output logic             oce,
  input  logic [7:0]       rd_data,
  output logic [7:0]       da_data,
  output logic             da_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [PER_W-1:0] MIN_PER = PER_W'(3);

  state_t           state_q;
  logic [13:0]      adb_q;
  logic             ceb_q;
  logic             oce_q;
  logic [7:0]       da_data_q;
  logic             da_strobe_q;
  logic             busy_q;
  logic             done_q;

  logic [13:0]      base_q;
  logic [14:0]      len_q;
  logic [PER_W-1:0] pm1_q;
  logic             loop_q;
  logic [13:0]      addr_q;
  logic [14:0]      rem_q;
  logic [PER_W-1:0] cnt_q;
  logic             v1_q;
  logic             v2_q;

  logic [PER_W-1:0] period_d;
  logic [PER_W-1:0] pm1_d;
  logic [14:0]      len_d;

  always_comb begin
    period_d = (period < MIN_PER) ? MIN_PER : period;
    pm1_d    = period_d - PER_W'(1);
    len_d    = (len == 14'd0) ? 15'd16384 : {1'b0, len};
  end

  // rem_q counts issues still owed after the current one; cnt_q counts down to the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      adb_q       <= 14'd0;
      ceb_q       <= 1'b0;
      oce_q       <= 1'b0;
      da_data_q   <= IDLE_CODE;
      da_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      base_q      <= 14'd0;
      len_q       <= 15'd0;
      pm1_q       <= '0;
      loop_q      <= 1'b0;
      addr_q      <= 14'd0;
      rem_q       <= 15'd0;
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
    end else begin
      v1_q        <= ceb_q;
      v2_q        <= v1_q;
      ceb_q       <= 1'b0;
      da_strobe_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          oce_q  <= 1'b0;
          // busy_q still high here means this is the final strobe cycle of the last run.
          if (start && !stop && !busy_q) begin
            base_q  <= base;
            len_q   <= len_d;
            pm1_q   <= pm1_d;
            loop_q  <= loop;
            ceb_q   <= 1'b1;
            adb_q   <= base;
            addr_q  <= base + 14'd1;
            rem_q   <= len_d - 15'd1;
            cnt_q   <= pm1_d;
            busy_q  <= 1'b1;
            oce_q   <= 1'b1;
            state_q <= (len_d == 15'd1 && !loop) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (stop) begin
            state_q   <= S_IDLE;
            ceb_q     <= 1'b0;
            oce_q     <= 1'b0;
            busy_q    <= 1'b0;
            da_data_q <= IDLE_CODE;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
          end else begin
            if (v2_q) begin
              da_data_q   <= rd_data;
              da_strobe_q <= 1'b1;
            end
            if (state_q == S_DRAIN) begin
              if (v2_q) begin
                done_q  <= 1'b1;
                oce_q   <= 1'b0;
                state_q <= S_IDLE;
              end
            end else if (cnt_q == '0) begin
              cnt_q <= pm1_q;
              ceb_q <= 1'b1;
              if (rem_q == 15'd0) begin
                // Only reachable in loop mode: wrap back to the start of the run.
                adb_q  <= base_q;
                addr_q <= base_q + 14'd1;
                rem_q  <= len_q - 15'd1;
              end else begin
                adb_q  <= addr_q;
                addr_q <= addr_q + 14'd1;
                rem_q  <= rem_q - 15'd1;
                if (rem_q == 15'd1 && !loop_q) begin
                  state_q <= S_DRAIN;
                end
              end
            end else begin
              cnt_q <= cnt_q - PER_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adb       = adb_q;
  assign ceb       = ceb_q;
  assign oce       = oce_q;
  assign da_data   = da_data_q;
  assign da_strobe = da_strobe_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_da_player.sv
// tb/tb_da_player.sv - directed bench for da_player with an event-schedule model and buffer model.
module tb_da_player;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_i = 1'b0;
  logic [13:0] base = 14'd0;
  logic [13:0] len = 14'd0;
  logic [15:0] period = 16'd0;
  logic [13:0] adb;
  logic        ceb;
  logic        oce;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  da_data;
  logic        da_strobe;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  da_player #(.IDLE_CODE(8'h80), .PER_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .base(base), .len(len), .period(period), .loop(loop_i),
    .adb(adb), .ceb(ceb), .oce(oce), .rd_data(rd_data),
    .da_data(da_data), .da_strobe(da_strobe), .busy(busy), .done(done)
  );

  // Buffer holds addr i = i[7:0]; two-edge pipelined read.
  logic [13:0] areg = 14'd0;
  always @(posedge clk) begin
    if (ceb) areg <= adb;
    if (oce) rd_data <= areg[7:0];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_start = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a run is a schedule of issues at 1+kP and strobes at 4+kP after the start edge.
  bit         m_act = 0;
  bit         m_loop = 0;
  int         m_t0 = 0, m_p = 3, m_n = 1, m_base = 0;
  logic [7:0] m_da = 8'h80;
  bit         e_ceb = 0, e_str = 0, e_done = 0, e_busy = 0;
  int         e_adb = 0;

  function automatic int addr_of(input int k);
    int idx;
    idx = m_loop ? (k % m_n) : k;
    return (m_base + idx) % 16384;
  endfunction

  task automatic model_eval();
    int rel, k, fin, a;
    e_ceb = 0; e_str = 0; e_done = 0; e_busy = 0;
    if (m_act) begin
      rel = cyc - m_t0;
      fin = 4 + (m_n - 1) * m_p;
      if (!m_loop && rel > fin) begin
        m_act = 0;
      end else begin
        e_busy = (rel >= 1);
        if (rel >= 1 && (rel - 1) % m_p == 0) begin
          k = (rel - 1) / m_p;
          if (m_loop || k < m_n) begin
            e_ceb = 1;
            e_adb = addr_of(k);
          end
        end
        if (rel >= 4 && (rel - 4) % m_p == 0) begin
          k = (rel - 4) / m_p;
          a = addr_of(k);
          e_str = 1;
          m_da = a[7:0];
        end
        e_done = !m_loop && rel == fin;
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0;
      m_da = 8'h80;
    end else if (stop && e_busy) begin
      m_act = 0;
      m_da = 8'h80;
    end else if (start && !stop && !e_busy) begin
      m_act = 1;
      m_t0 = cyc;
      m_p = (period < 16'd3) ? 3 : int'(period);
      m_n = (len == 14'd0) ? 16384 : int'(len);
      m_base = int'(base);
      m_loop = loop_i;
    end
    cyc++;
    model_eval();
  end

  // Event log for the literal checks, relative to the start edge.
  int s_rel[$];
  int s_dat[$];
  int i_rel[$];
  int i_adr[$];
  int done_rel = -1;
  int last_busy = -1;

  always @(negedge clk) begin
    int rel;
    rel = cyc - t_start;
    if (reset) begin
      chk("rst_adb", 32'(adb), 32'd0);
      chk("rst_ceb", 32'(ceb), 32'd0);
      chk("rst_oce", 32'(oce), 32'd0);
      chk("rst_da", 32'(da_data), 32'h80);
      chk("rst_strobe", 32'(da_strobe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end else begin
      chk("ceb", 32'(ceb), 32'(e_ceb));
      if (e_ceb) begin
        chk("adb", 32'(adb), 32'(e_adb));
        chk("oce", 32'(oce), 32'd1);
      end
      chk("strobe", 32'(da_strobe), 32'(e_str));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("da_data", 32'(da_data), 32'(m_da));
      if (da_strobe) begin
        s_rel.push_back(rel);
        s_dat.push_back(int'(da_data));
      end
      if (ceb) begin
        i_rel.push_back(rel);
        i_adr.push_back(int'(adb));
      end
      if (done) done_rel = rel;
      if (busy) last_busy = rel;
    end
  end

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    s_rel.delete(); s_dat.delete(); i_rel.delete(); i_adr.delete();
    done_rel = -1;
    last_busy = -1;
  endtask

  task automatic do_start(input logic [13:0] b, input logic [13:0] l, input logic [15:0] p, input logic lp);
    base = b; len = l; period = p; loop_i = lp;
    start = 1'b1;
    t_start = cyc;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);

    // Basic run
    clear_log();
    do_start(14'h0010, 14'd4, 16'd5, 1'b0);
    tick(24);
    chk("t1_nstrobe", 32'(s_rel.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_srel", 32'(qget(s_rel, i)), 32'(4 + 5 * i));
      chk("t1_sdat", 32'(qget(s_dat, i)), 32'(8'h10 + i));
    end
    chk("t1_done", 32'(done_rel), 32'd19);
    chk("t1_lastbusy", 32'(last_busy), 32'd19);

    // Wrap and clamp
    clear_log();
    do_start(14'h3FFE, 14'd3, 16'd1, 1'b0);
    tick(14);
    chk("t2_irel0", 32'(qget(i_rel, 0)), 32'd1);
    chk("t2_irel1", 32'(qget(i_rel, 1)), 32'd4);
    chk("t2_irel2", 32'(qget(i_rel, 2)), 32'd7);
    chk("t2_iadr0", 32'(qget(i_adr, 0)), 32'h3FFE);
    chk("t2_iadr1", 32'(qget(i_adr, 1)), 32'h3FFF);
    chk("t2_iadr2", 32'(qget(i_adr, 2)), 32'h0000);
    chk("t2_srel0", 32'(qget(s_rel, 0)), 32'd4);
    chk("t2_srel2", 32'(qget(s_rel, 2)), 32'd10);
    chk("t2_sdat2", 32'(qget(s_dat, 2)), 32'h00);
    chk("t2_done", 32'(done_rel), 32'd10);

    // Loop, then stop
    clear_log();
    do_start(14'h0100, 14'd2, 16'd4, 1'b1);
    tick(18);
    chk("t3_nissue", 32'(i_rel.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_irel", 32'(qget(i_rel, i)), 32'(1 + 4 * i));
      chk("t3_iadr", 32'(qget(i_adr, i)), 32'(14'h0100 + (i % 2)));
    end
    chk("t3_nodone", 32'(done_rel), 32'hFFFFFFFF);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("t3_stop_da", 32'(da_data), 32'h80);
    chk("t3_stop_busy", 32'(busy), 32'd0);
    tick(3);

    // Abort with capture pending
    clear_log();
    do_start(14'h0020, 14'd5, 16'd6, 1'b0);
    tick(7);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(12);
    chk("t4_nstrobe", 32'(s_rel.size()), 32'd1);
    chk("t4_sdat0", 32'(qget(s_dat, 0)), 32'h20);
    chk("t4_nodone", 32'(done_rel), 32'hFFFFFFFF);
    chk("t4_da", 32'(da_data), 32'h80);
    chk("t4_lastbusy", 32'(last_busy), 32'd8);

    // Start while busy is ignored
    clear_log();
    do_start(14'h0030, 14'd3, 16'd4, 1'b0);
    tick(3);
    base = 14'h1000; len = 14'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("t5_nstrobe", 32'(s_rel.size()), 32'd3);
    chk("t5_sdat2", 32'(qget(s_dat, 2)), 32'h32);
    chk("t5_iadr2", 32'(qget(i_adr, 2)), 32'h0032);
    chk("t5_done", 32'(done_rel), 32'd12);

    // Stop wins over start in IDLE
    clear_log();
    base = 14'h0200; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(4);
    chk("t5_ss_nissue", 32'(i_rel.size()), 32'd0);
    chk("t5_ss_busy", 32'(busy), 32'd0);

    // len = 0 plays 16384 samples
    clear_log();
    do_start(14'h0000, 14'd0, 16'd3, 1'b0);
    for (int i = 0; i < 49300 && done_rel < 0; i++) tick(1);
    chk("t6_done", 32'(done_rel), 32'd49153);
    tick(3);
    chk("t6_nstrobe", 32'(s_rel.size()), 32'd16384);
    chk("t6_lastdat", 32'(da_data), 32'hFF);
    chk("t6_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run
    clear_log();
    do_start(14'h0040, 14'd4, 16'd5, 1'b0);
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_adb", 32'(adb), 32'd0);
    chk("t7_ceb", 32'(ceb), 32'd0);
    chk("t7_oce", 32'(oce), 32'd0);
    chk("t7_da", 32'(da_data), 32'h80);
    chk("t7_strobe", 32'(da_strobe), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("t7_nodone", 32'(done_rel), 32'hFFFFFFFF);
    chk("t7_nstrobe", 32'(s_rel.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/da_player.md
# da_player

Playback sequencer on the read port of the 16K x 8 receive buffer (pipelined read mode: address registered, output register enabled by OCE, two-edge read latency). It fetches a programmed run of bytes from the buffer and presents them to the DAC interface at a fixed sample period, with optional looping. It runs entirely in the buffer's read-clock domain.

## Interface
Parameters:
- `IDLE_CODE`, 8'h80: DAC code driven at reset, when idle, and after abort (offset-binary midscale).
- `PER_W`, 16: width of the sample-period input.

Ports:
- `clk`: input, 1. Read-side clock, same net as the buffer's `clkb`. One clock; reset is asynchronous and active-high.
- `reset`: input, 1. Asynchronous, active-high. Also drives the buffer's `reset`.
- `start`: input, 1. Single-cycle pulse. Latches `base`, `len`, `period` and `loop`, then begins playback. Ignored while `busy`.
- `stop`: input, 1. Aborts playback. Takes priority over `start` in the same cycle.
- `base`: input, 14. First buffer address.
- `len`: input, 14. Sample count; 0 means 16384.
- `period`: input, PER_W. Clock cycles per sample; values below 3 are treated as 3.
- `loop`: input, 1. When 1, restart at `base` after the last sample instead of finishing.
- `adb`: output, 14. Buffer read address.
- `ceb`: output, 1. Buffer read enable.
- `oce`: output, 1. Buffer output-register enable.
- `rd_data`: input, 8. Buffer `dout`.
- `da_data`: output, 8. DAC sample, held between strobes.
- `da_strobe`: output, 1. One-cycle pulse in the first cycle a new `da_data` is visible.
- `busy`: output, 1. High from the first issue cycle through the final strobe cycle.
- `done`: output, 1. One-cycle pulse coincident with the final `da_strobe` of a non-looping run.

## Operation
- All outputs are registered.
- Reset values: `adb`=0, `ceb`=0, `oce`=0, `da_data`=IDLE_CODE, `da_strobe`=0, `busy`=0, `done`=0. Internal state is IDLE.
- States:
  - IDLE: `busy`=0, `ceb`=0, `oce`=0. A `start` pulse latches the parameters and moves to RUN.
  - RUN: issues one read every `period` cycles. An issue cycle drives `ceb`=1 and `adb`=current address; `ceb`=0 in all other cycles. `oce`=1 throughout RUN and DRAIN.
  - DRAIN: entered after the last issue of a non-looping run. Waits for the final capture, pulses `da_strobe` and `done` together, then returns to IDLE.
- Addressing:
  - Address advances by 1 per issue, modulo 16384: 16383 is followed by 0.
  - The remaining-sample counter is 15 bits wide so that `len`=0 loads 16384.
- Loop mode: after the issue for sample `len`, the next issue (exactly `period` cycles later) uses `base` again. The count reloads and `done` never pulses.
- Capture: `rd_data` is sampled 2 cycles after each issue cycle into `da_data`. It is tracked by a 2-stage issue-valid shift register, so the pipeline tolerates any clamped period of 3 or more.
- Abort (`stop`=1 in RUN or DRAIN):
  - Next cycle: IDLE, `ceb`=0, `busy`=0, `da_data`=IDLE_CODE.
  - In-flight captures are discarded; no `done`.
  - `stop` in IDLE has no effect.
- `start` while busy: ignored; latched parameters are unchanged.
- Reset asserted mid-run: outputs take their reset values immediately (asynchronously); no `done`.
- `da_data` keeps the last sample after a normal finish.

## Timing
- `start` sampled high at the edge ending cycle 0:
  - Cycle 1: first issue (`ceb`=1, `adb`=`base`, `busy`=1).
  - Cycle 4: first `da_strobe`, new `da_data` visible.
- Issue k (0-based) happens in cycle 1 + k·P, where P is the clamped period. Strobe k follows in cycle 4 + k·P.
- Non-looping run of N samples: final strobe and `done` in cycle 4 + (N−1)·P. `busy` falls in the next cycle.
- A new `start` is accepted in the first cycle after `busy` is low.
- `stop` sampled at the edge ending cycle s: the cycle s+1 outputs are already in their idle values.

## Test plan
- **Basic run.** Buffer holds addr i = i[7:0]; `base`=0x0010, `len`=4, `period`=5. Expect strobes in cycles 4, 9, 14, 19 carrying 0x10, 0x11, 0x12, 0x13; `done` in cycle 19; `busy` low from cycle 20.
- **Wrap and clamp.** `base`=0x3FFE, `len`=3, `period`=1 (clamped to 3). Expect issues on addresses 0x3FFE, 0x3FFF, 0x0000 in cycles 1, 4, 7; strobes in cycles 4, 7, 10.
- **Loop.** `loop`=1, `base`=0x0100, `len`=2, `period`=4. Expect `adb` sequence 0x0100, 0x0101, 0x0100, 0x0101 … with issues every 4 cycles and no `done`. `stop` then gives `da_data`=0x80 and `busy`=0 one cycle later.
- **Abort with capture pending.** `stop` in the cycle right after an issue. Expect no further `da_strobe`, `da_data`=0x80, no `done`.
- **Start while busy, and stop-over-start.** A `start` with different `base` mid-run: the run continues unchanged. `start` and `stop` together in IDLE: stays idle.
- **len=0 and reset mid-run.** `len`=0, `period`=3: `done` in cycle 4 + 16383·3 = 49153. In a separate run, asserting `reset` mid-run forces all outputs to reset values within the same cycle.
